fir_decim_fifo: RTL and testbench
=================================

# fir_decim_fifo

Downstream stage of the 31-tap FIR filter. Takes the filter's 18-bit signed output on each `done` pulse and keeps one of every `DECIM` results. Each kept result is requantized to 8-bit signed (round, shift, optional saturate) and buffered in a small first-word-fall-through FIFO. The consumer (audio out / display path) drains the FIFO with a read strobe.

## Interface
- `DECIM`, 4: decimation factor, 1..16; `DECIM=1` keeps every sample.
- `DEPTH`, 8: FIFO depth in entries; power of two, 2..64.
- `SHIFT`, 10: right-shift applied during requantize (matches coefficient scaling 2**10); 1..10.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `din`  in  18  signed filter result; sampled only when `din_valid`=1.
- `din_valid`  in  1  one-cycle strobe, driven from the filter's `done`.
- `rd_en`  in  1  pop head entry this cycle; ignored while `empty`.
- `clear_ovf`  in  1  clears sticky `overflow`.
- `dout`  out  8  signed head of FIFO (fall-through); forced 0 while `empty`.
- `empty`  out  1  FIFO holds no entries.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `count`  out  clog2(DEPTH)+1  entries held.
- `overflow`  out  1  sticky; a kept sample was dropped because FIFO was full.

## Operation
- Phase counter `ph` runs 0..DECIM-1. It advances on every `din_valid` and wraps to 0 after `DECIM-1`. A sample is kept only when `ph`==0 at its strobe.
- `ph` advances whether or not the kept sample is dropped for full.
- Requantize, in 19-bit signed arithmetic: `r = (din + 2**(SHIFT-1)) >>> SHIFT`. The shift is arithmetic and rounds half up. No wrap occurs inside the 19-bit add.
- Narrowing `r` to 8 bits is governed by the Configuration section.
- Push: kept sample and `!full`, or kept sample and `full` and `rd_en` in the same cycle. In both cases the entry is written at `wr_ptr` and `wr_ptr` increments mod `DEPTH`.
- Drop: kept sample, `full`, and `!rd_en`. The sample is discarded and `overflow` is set.
- Pop: `rd_en` and `!empty`. `rd_ptr` increments mod `DEPTH`.
- `count` bookkeeping:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged.
- Push while `empty` with `rd_en`=1: the pop is ignored and the entry lands.
- `rd_en` while `empty`: no effect, no error flag.
- `overflow`: set on drop, cleared by `clear_ovf`. If both happen in the same cycle, set wins.
- Reset (async assert): `ph`, `wr_ptr`, `rd_ptr` and `count` go to 0. Outputs go to `empty`=1, `full`=0, `overflow`=0, `dout`=0. Storage contents are not reset.
- Reset mid-operation discards all buffered entries and the decimation phase.
- Release is synchronous-safe: the first edge after deassertion may accept `din_valid`.

## Timing
- Push latency: a kept `din_valid` at edge N gives `empty`=0, `count` updated and `dout` showing the entry after edge N. There is 1 cycle from strobe to visible data.
- Pop: `rd_en` at edge N makes the next entry visible on `dout` after edge N. `dout` is combinational from storage at `rd_ptr`.
- `din_valid` may be asserted on consecutive cycles; the block sustains one accept per clock.
- The filter produces at most one strobe per 32 clocks, so the FIFO drains at any consumer rate ≥ input rate/`DECIM`.
- `full`, `empty` and `count` are registered state, updated on the same edge as the pointers.

## Configuration
- `FIR_DECIM_SAT_EN` defined: `r` is clamped to [−128, 127] before storing.
- `FIR_DECIM_SAT_EN` undefined: the low 8 bits of `r` are stored (two's-complement wrap). The saturation comparators are not built.
- `overflow` semantics are identical in both builds. It flags FIFO drops only, never arithmetic clipping.

## Test plan
- Round/shift (SHIFT=10, DECIM=1), each checked on `dout` after one push/pop:
  - `din`=1000 → `dout`=1.
  - `din`=511 → 0.
  - `din`=512 → 1.
  - `din`=−512 → 0.
  - `din`=−513 → −1.
- Extremes:
  - `din`=131071: with `FIR_DECIM_SAT_EN` → 127; without → −128.
  - `din`=−131072: −128 in both builds.
- Decimation (DECIM=4): 8 strobes with `din`=k·1024, k=1..8 → exactly 2 entries, values 1 then 5; `count`=2.
- Overflow (DEPTH=8, DECIM=1): 9 strobes with `din`=k·1024, no reads.
  - After 8 strobes: `full`=1, `count`=8.
  - After the 9th: `overflow`=1, and 8 reads return 1..8 then `empty`=1.
  - `clear_ovf` then returns `overflow`=0.
- Simultaneous events:
  - `full` + strobe + `rd_en` in one cycle → `count` stays 8, `overflow` stays 0, new value appears last.
  - `empty` + strobe + `rd_en` → `count`=1.
- Reset mid-operation: with 3 entries buffered and `ph`=2, pulse `reset` low between edges.
  - Immediately: `empty`=1, `count`=0, `dout`=0.
  - After release, the next strobe is kept (`ph`=0).

Source files
------------

// File: rtl/fir_decim_fifo.sv
// Decimating requantizer plus first-word-fall-through FIFO behind the 31-tap FIR.
// Define FIR_DECIM_SAT_EN to clamp requantized samples to [-128,127] instead of wrapping.
module fir_decim_fifo #(
  parameter int DECIM = 4,
  parameter int DEPTH = 8,
  parameter int SHIFT = 10
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic signed [17:0]        din,
  input  logic                      din_valid,
  input  logic                      rd_en,
  input  logic                      clear_ovf,
  output logic signed [7:0]         dout,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic signed [18:0] HALF = 19'(2 ** (SHIFT - 1));

  logic [PW-1:0]     ph;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic signed [7:0] mem [DEPTH];

  logic signed [18:0] sum;
  logic signed [18:0] r;
  logic signed [7:0]  q;
  logic               keep;
  logic               push;
  logic               pop;
  logic               drop;
  logic [CW-1:0]      count_next;

  // Sign-extend to 19 bits so the rounding add can never wrap.
  assign sum = $signed({din[17], din}) + HALF;
  assign r   = sum >>> SHIFT;

`ifdef FIR_DECIM_SAT_EN
  assign q = (r > 19'sd127)  ? 8'sd127 :
             (r < -19'sd128) ? -8'sd128 : r[7:0];
`else
  logic unused_hi;
  assign unused_hi = ^r[18:8];
  assign q = r[7:0];
`endif

  assign keep = din_valid && (ph == '0);
  assign push = keep && (!full || rd_en);
  assign drop = keep && full && !rd_en;
  assign pop  = rd_en && !empty;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ph       <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (din_valid)
        ph <= (ph == PW'(DECIM - 1)) ? '0 : ph + 1'b1;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CW'(DEPTH));
      if (drop)
        overflow <= 1'b1;
      else if (clear_ovf)
        overflow <= 1'b0;
    end
  end

  // NOTE: storage is deliberately not reset; empty gates dout, so stale contents never escape.
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= q;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Directed bench for fir_decim_fifo: one DECIM=1 instance and one DECIM=4 instance.
module tb_fir_decim_fifo;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic signed [17:0] din1, din4;
  logic               valid1, valid4, rd1, rd4, clr1, clr4;
  logic signed [7:0]  dout1, dout4;
  logic               empty1, empty4, full1, full4, ovf1, ovf4;
  logic [3:0]         count1, count4;

  int total = 0;
  int bad   = 0;

  fir_decim_fifo #(.DECIM(1), .DEPTH(8), .SHIFT(10)) u_d1 (
    .clock(clock), .reset(reset), .din(din1), .din_valid(valid1), .rd_en(rd1),
    .clear_ovf(clr1), .dout(dout1), .empty(empty1), .full(full1), .count(count1),
    .overflow(ovf1)
  );

  fir_decim_fifo #(.DECIM(4), .DEPTH(8), .SHIFT(10)) u_d4 (
    .clock(clock), .reset(reset), .din(din4), .din_valid(valid4), .rd_en(rd4),
    .clear_ovf(clr4), .dout(dout4), .empty(empty4), .full(full4), .count(count4),
    .overflow(ovf4)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock of stimulus on the DECIM=1 instance; outputs are stable at the following negedge.
  task automatic drive1(input logic v, input int d, input logic rd, input logic clr);
    @(negedge clock);
    valid1 = v; din1 = 18'(d); rd1 = rd; clr1 = clr;
    @(negedge clock);
    valid1 = 1'b0; rd1 = 1'b0; clr1 = 1'b0;
  endtask

  task automatic drive4(input logic v, input int d, input logic rd);
    @(negedge clock);
    valid4 = v; din4 = 18'(d); rd4 = rd;
    @(negedge clock);
    valid4 = 1'b0; rd4 = 1'b0;
  endtask

  task automatic round_case(input string tag, input int d, input int exp);
    drive1(1'b1, d, 1'b0, 1'b0);
    check(tag, int'(dout1), exp);
    drive1(1'b0, 0, 1'b1, 1'b0);
  endtask

  initial begin
    din1 = '0; din4 = '0;
    valid1 = 0; valid4 = 0; rd1 = 0; rd4 = 0; clr1 = 0; clr4 = 0;
    #12;
    check("rst_empty", int'(empty1), 1);
    check("rst_full",  int'(full1),  0);
    check("rst_count", int'(count1), 0);
    check("rst_ovf",   int'(ovf1),   0);
    check("rst_dout",  int'(dout1),  0);
    reset = 1'b1;

    // Round half up, arithmetic shift by 10.
    round_case("rnd_1000",  1000,    1);
    round_case("rnd_511",   511,     0);
    round_case("rnd_512",   512,     1);
    round_case("rnd_m512",  -512,    0);
    round_case("rnd_m513",  -513,   -1);
`ifdef FIR_DECIM_SAT_EN
    round_case("ext_max",   131071,  127);
`else
    round_case("ext_max",   131071, -128);
`endif
    round_case("ext_min",   -131072, -128);
    check("rnd_empty", int'(empty1), 1);

    // Read while empty does nothing.
    drive1(1'b0, 0, 1'b1, 1'b0);
    check("rd_empty_count", int'(count1), 0);
    check("rd_empty_ovf",   int'(ovf1),   0);

    // Fill past capacity without reading.
    for (int k = 1; k <= 8; k++) drive1(1'b1, k * 1024, 1'b0, 1'b0);
    check("fill_full",  int'(full1),  1);
    check("fill_count", int'(count1), 8);
    check("fill_ovf",   int'(ovf1),   0);
    drive1(1'b1, 9 * 1024, 1'b0, 1'b0);
    check("drop_ovf",   int'(ovf1),   1);
    check("drop_count", int'(count1), 8);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("drain_%0d", k), int'(dout1), k);
      drive1(1'b0, 0, 1'b1, 1'b0);
    end
    check("drain_empty", int'(empty1), 1);
    check("drain_dout",  int'(dout1),  0);
    drive1(1'b0, 0, 1'b0, 1'b1);
    check("clr_ovf", int'(ovf1), 0);

    // Full + strobe + read: push and pop together.
    for (int k = 1; k <= 8; k++) drive1(1'b1, k * 1024, 1'b0, 1'b0);
    drive1(1'b1, 9 * 1024, 1'b1, 1'b0);
    check("sim_full_count", int'(count1), 8);
    check("sim_full_ovf",   int'(ovf1),   0);
    check("sim_full_head",  int'(dout1),  2);
    for (int k = 2; k <= 9; k++) begin
      if (k == 9) check("sim_full_last", int'(dout1), 9);
      drive1(1'b0, 0, 1'b1, 1'b0);
    end
    check("sim_full_empty", int'(empty1), 1);

    // Empty + strobe + read: pop ignored, entry lands.
    drive1(1'b1, -3 * 1024, 1'b1, 1'b0);
    check("sim_empty_count", int'(count1), 1);
    check("sim_empty_dout",  int'(dout1), -3);
    drive1(1'b0, 0, 1'b1, 1'b0);

    // Decimation by 4: keep strobes 1 and 5.
    for (int k = 1; k <= 8; k++) drive4(1'b1, k * 1024, 1'b0);
    check("dec_count", int'(count4), 2);
    check("dec_first", int'(dout4),  1);
    drive4(1'b0, 0, 1'b1);
    check("dec_second", int'(dout4), 5);
    drive4(1'b0, 0, 1'b1);
    check("dec_empty", int'(empty4), 1);

    // Three entries buffered with phase 2, then an async reset pulse between edges.
    for (int k = 1; k <= 10; k++) drive4(1'b1, k * 1024, 1'b0);
    check("pre_rst_count", int'(count4), 3);
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_empty", int'(empty4), 1);
    check("mid_rst_count", int'(count4), 0);
    check("mid_rst_dout",  int'(dout4),  0);
    #1 reset = 1'b1;
    drive4(1'b1, 3 * 1024, 1'b0);
    check("post_rst_kept",  int'(dout4),  3);
    check("post_rst_count", int'(count4), 1);
    drive4(1'b1, 7 * 1024, 1'b0);
    check("post_rst_skip",  int'(count4), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
